// File: rtl/otp_pkg.sv
// Shared types and widths for the one-time-pad word sequencer slice.
package otp_pkg;
  localparam int OTP_WORD_W = 16;
  localparam int BYTE_W     = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    RELEASE = 3'd3,
    OUT     = 3'd4
  } otp_state_e;
endpackage

// File: rtl/otp_word_fifo.sv
// Small word FIFO with wrap-around pointers; a push is accepted when full only if a pop happens in the same cycle.
module otp_word_fifo
  import otp_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [OTP_WORD_W-1:0] din,
  input  logic                  pop,
  output logic [OTP_WORD_W-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic [AW:0]           count
);
  logic [OTP_WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/otp_word_sequencer.sv
// Packs bytes into 16-bit words, queues them, and walks each word through the
// encryption block's start/done handshake before presenting it downstream.
module otp_word_sequencer
  import otp_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15,
  localparam int AW = $clog2(DEPTH),
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BYTE_W-1:0]     in_byte,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  bypass,
  output logic [OTP_WORD_W-1:0] enc_data,
  output logic                  enc_start,
  output logic                  enc_passthrough,
  input  logic [OTP_WORD_W-1:0] enc_result,
  input  logic                  enc_done,
  output logic [OTP_WORD_W-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow,
  output logic                  timeout_err,
  output logic [2:0]            state_dbg,
  output logic [AW:0]           fifo_level_dbg
);
  otp_state_e            state;
  logic                  half;
  logic [BYTE_W-1:0]     hi_byte;
  logic                  pair_done;
  logic [OTP_WORD_W-1:0] packed_word;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [OTP_WORD_W-1:0] fifo_dout;
  logic [TW-1:0]         wait_cnt;

  // Both streams use valid/ready: a beat transfers on the rising edge where
  // valid && ready; the producer holds data stable until that edge.
  assign in_ready    = 1'b1;
  assign pair_done   = in_valid && half;
  assign packed_word = {hi_byte, in_byte};
  assign fifo_pop    = (state == IDLE) && !fifo_empty;
  assign state_dbg   = state;

  otp_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (pair_done),
    .din   (packed_word),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_level_dbg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      half     <= 1'b0;
      hi_byte  <= '0;
      overflow <= 1'b0;
    end else begin
      if (in_valid) begin
        if (!half) hi_byte <= in_byte;
        half <= !half;
      end
      // A pop in the same cycle frees a slot, so only a stalled full FIFO drops.
      if (pair_done && fifo_full && !fifo_pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      enc_data        <= '0;
      enc_start       <= 1'b0;
      enc_passthrough <= 1'b0;
      out_data        <= '0;
      out_valid       <= 1'b0;
      timeout_err     <= 1'b0;
      wait_cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            enc_data        <= fifo_dout;
            enc_passthrough <= bypass;
            enc_start       <= 1'b1;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (enc_done) begin
            out_data  <= enc_result;
            enc_start <= 1'b0;
            state     <= RELEASE;
          end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            out_data    <= '0;
            enc_start   <= 1'b0;
            state       <= RELEASE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        // One low cycle lets the encryption block unlock before the next start.
        RELEASE: begin
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_otp_word_sequencer.sv
// Directed and randomized bench for otp_word_sequencer with a behavioural encryption block.
module tb_otp_word_sequencer;
  localparam int DEPTH = 4;
  localparam logic [15:0] KEY = 16'h3327;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_byte = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        bypass = 1'b0;
  logic [15:0] enc_data;
  logic        enc_start;
  logic        enc_passthrough;
  logic [15:0] enc_result = '0;
  logic        enc_done = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        overflow;
  logic        timeout_err;
  logic [2:0]  state_dbg;
  logic [2:0]  fifo_level_dbg;

  int total = 0;
  int bad = 0;

  logic [15:0] exp_q[$];
  logic        half_b = 1'b0;
  logic [7:0]  hi_b = '0;
  int          held = 0;
  int          drop_cnt = 0;

  int          enc_delay = 0;
  logic        enc_hang = 1'b0;
  logic        enc_armed = 1'b1;
  int          enc_cnt = 0;

  int          mon_cyc = 0;
  int          start_rises = 0;
  int          last_rise_cyc = 0;
  int          last_period = 0;
  int          low_run = 0;
  int          last_gap = 0;
  int          stab_err = 0;
  logic        prev_start = 1'b0;
  logic [15:0] rise_data = '0;
  logic        rise_pt = 1'b0;

  otp_word_sequencer #(.DEPTH(DEPTH), .TIMEOUT(15)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_byte         (in_byte),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .bypass          (bypass),
    .enc_data        (enc_data),
    .enc_start       (enc_start),
    .enc_passthrough (enc_passthrough),
    .enc_result      (enc_result),
    .enc_done        (enc_done),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .overflow        (overflow),
    .timeout_err     (timeout_err),
    .state_dbg       (state_dbg),
    .fifo_level_dbg  (fifo_level_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Encryption block: latches on a start it has not yet served, answers after
  // enc_delay further cycles, and unlocks only when start goes low.
  always @(posedge clk) begin
    if (reset || !enc_start) begin
      enc_done  <= 1'b0;
      enc_armed <= 1'b1;
      enc_cnt   <= 0;
    end else if (enc_armed) begin
      enc_armed  <= 1'b0;
      enc_result <= enc_passthrough ? enc_data : (enc_data ^ KEY);
      enc_cnt    <= enc_delay;
      enc_done   <= (enc_delay == 0) && !enc_hang;
    end else if (!enc_done && !enc_hang) begin
      if (enc_cnt <= 1) enc_done <= 1'b1;
      enc_cnt <= enc_cnt - 1;
    end
  end

  // start-pulse monitor
  always @(negedge clk) begin
    mon_cyc++;
    if (reset) begin
      prev_start = 1'b0;
      low_run = 0;
    end else begin
      if (enc_start && !prev_start) begin
        start_rises++;
        last_period = mon_cyc - last_rise_cyc;
        last_rise_cyc = mon_cyc;
        last_gap = low_run;
        rise_data = enc_data;
        rise_pt = enc_passthrough;
      end else if (enc_start && (enc_data !== rise_data || enc_passthrough !== rise_pt)) begin
        stab_err++;
      end
      if (enc_start) low_run = 0;
      else low_run++;
      prev_start = enc_start;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [15:0] w;
    in_byte = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    if (!half_b) begin
      hi_b = b;
      half_b = 1'b1;
    end else begin
      half_b = 1'b0;
      w = {hi_b, b};
      if (held >= DEPTH + 1) begin
        drop_cnt++;
      end else begin
        exp_q.push_back(enc_hang ? 16'h0000 : (bypass ? w : (w ^ KEY)));
        held++;
      end
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    half_b = 1'b0;
    held = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_enc_data"}, {16'd0, enc_data}, 32'd0);
    check({tag, "_enc_start"}, {31'd0, enc_start}, 32'd0);
    check({tag, "_enc_pt"}, {31'd0, enc_passthrough}, 32'd0);
    check({tag, "_out_data"}, {16'd0, out_data}, 32'd0);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
    check({tag, "_timeout"}, {31'd0, timeout_err}, 32'd0);
    check({tag, "_state"}, {29'd0, state_dbg}, 32'd0);
    check({tag, "_fifo_lvl"}, {29'd0, fifo_level_dbg}, 32'd0);
  endtask

  // Waits for out_valid (cycle 1 = first cycle after the last byte edge),
  // compares against the scoreboard, stalls, then completes the handshake.
  task automatic wait_out(input string tag, input int exp_lat, input int stall);
    int cyc_l;
    logic [15:0] e;
    cyc_l = 1;
    while (!out_valid && cyc_l < 400) begin
      tick();
      cyc_l++;
    end
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    if (exp_lat > 0) check({tag, "_latency"}, cyc_l, exp_lat);
    check({tag, "_queued"}, {31'd0, (exp_q.size() != 0)}, 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'h0000;
    if (held > 0) held--;
    check({tag, "_data"}, {16'd0, out_data}, {16'd0, e});
    for (int s = 0; s < stall; s++) begin
      out_ready = 1'b0;
      tick();
      check({tag, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_stall_data"}, {16'd0, out_data}, {16'd0, e});
    end
    out_ready = 1'b1;
    tick();
    check({tag, "_released"}, {31'd0, out_valid}, 32'd0);
  endtask

  // directed and random steps
  initial begin
    int rises0;
    logic [7:0] b0;
    logic [7:0] b1;

    reset = 1'b1;
    tick();
    check_reset_vals("reset");
    tick();
    reset = 1'b0;
    tick();

    // basic encrypt: 12 34 -> 2113, out_valid five cycles after second byte
    out_ready = 1'b1;
    bypass = 1'b0;
    enc_delay = 0;
    send_byte(8'h12);
    send_byte(8'h34);
    check("enc_model_word", {16'd0, exp_q[0]}, 32'h2113);
    wait_out("enc", 5, 0);
    check("enc_pt_low", {31'd0, rise_pt}, 32'd0);

    // bypass: result equals the packed word, passthrough seen at start
    bypass = 1'b1;
    send_byte(8'h12);
    send_byte(8'h34);
    check("byp_model_word", {16'd0, exp_q[0]}, 32'h1234);
    wait_out("byp", 5, 1);
    check("byp_pt_high", {31'd0, rise_pt}, 32'd1);
    bypass = 1'b0;

    // back-to-back words
    rises0 = start_rises;
    send_byte(8'hA5);
    send_byte(8'h5A);
    send_byte(8'hC3);
    send_byte(8'h3C);
    wait_out("b2b0", -1, 0);
    wait_out("b2b1", -1, 0);
    check("b2b_rises", start_rises - rises0, 2);
    check("b2b_gap_nonzero", {31'd0, (last_gap >= 1)}, 32'd1);
    check("b2b_period", {31'd0, (last_period >= 5)}, 32'd1);

    // timeout: 15 WAIT cycles, then zero result; next word normal
    enc_hang = 1'b1;
    send_byte(8'h0F);
    send_byte(8'hF0);
    check("to_before", {31'd0, timeout_err}, 32'd0);
    wait_out("to", 19, 0);
    check("to_sticky", {31'd0, timeout_err}, 32'd1);
    enc_hang = 1'b0;
    send_byte(8'h44);
    send_byte(8'h55);
    wait_out("after_to", 5, 0);

    // overflow: one in flight plus DEPTH queued; the sixth word is dropped
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(0, 255)));
    check("ovf_none_yet", {31'd0, overflow}, 32'd0);
    send_byte(8'h99);
    send_byte(8'h66);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    check("ovf_model_drop", drop_cnt, 1);
    wait_out("ovf0", -1, 2);
    for (int i = 1; i < 5; i++) wait_out("ovf_n", -1, 0);
    check("ovf_drained", exp_q.size(), 0);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    check("to_still_sticky", {31'd0, timeout_err}, 32'd1);

    // reset during WAIT with a half-packed byte pending
    enc_hang = 1'b1;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h77);
    tick();
    tick();
    check("mid_in_wait", {31'd0, enc_start}, 32'd1);
    reset = 1'b1;
    tick();
    check_reset_vals("midrst");
    reset = 1'b0;
    enc_hang = 1'b0;
    clear_model();
    tick();
    send_byte(8'hAB);
    send_byte(8'hCD);
    check("midrst_model_word", {16'd0, exp_q[0]}, 32'h98EA);
    wait_out("midrst", 5, 0);

    // random single words: latency follows the block's response delay
    for (int i = 0; i < 10; i++) begin
      bypass = 1'($urandom_range(0, 1));
      enc_delay = $urandom_range(0, 4);
      b0 = 8'($urandom_range(0, 255));
      b1 = 8'($urandom_range(0, 255));
      send_byte(b0);
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      send_byte(b1);
      wait_out("rnd", 5 + enc_delay, $urandom_range(0, 3));
    end

    // random bursts with the FIFO filling behind the in-flight word
    for (int r = 0; r < 3; r++) begin
      bypass = 1'($urandom_range(0, 1));
      enc_delay = $urandom_range(0, 3);
      for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(0, 255)));
      for (int i = 0; i < 3; i++) wait_out("burst", -1, $urandom_range(0, 2));
    end

    check("final_queue_empty", exp_q.size(), 0);
    check("enc_inputs_stable", stab_err, 0);
    check("final_overflow_clear", {31'd0, overflow}, 32'd0);
    check("final_timeout_clear", {31'd0, timeout_err}, 32'd0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
